byte_egress: RTL and testbench



---
 rtl/byte_egress_if.sv | 29 ++
 rtl/byte_egress.sv | 168 ++++++++++++++++
 tb/tb_byte_egress.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/byte_egress_if.sv
// -----------------------------------------------------------------------------
// byte_egress_if
// Bundles the two handshakes of the word-to-byte serializer:
//   word side : TxWord[31:0], TxWordValid (core -> block), TxWordRdy (block -> core)
//   byte side : Data[7:0], DataValid (block -> sink), Rdyn (sink -> block, active low)
//   status    : Busy (block -> core)
// Modports:
//   slave  - the serializer's view (consumes words, produces bytes)
//   master - the environment's view (core plus byte sink)
// -----------------------------------------------------------------------------
interface byte_egress_if;
   logic [31:0] TxWord;
   logic        TxWordValid;
   logic        TxWordRdy;
   logic [7:0]  Data;
   logic        DataValid;
   logic        Rdyn;
   logic        Busy;

   modport slave (
      input  TxWord, TxWordValid, Rdyn,
      output TxWordRdy, Data, DataValid, Busy
   );

   modport master (
      output TxWord, TxWordValid, Rdyn,
      input  TxWordRdy, Data, DataValid, Busy
   );
endinterface

// File: rtl/byte_egress.sv
// -----------------------------------------------------------------------------
// byte_egress
// Word-to-byte serializer for the housekeeper byte link. Takes 32-bit words
// from the housekeeper core and emits them as four bytes toward the UART
// transmitter. A one-word pending buffer lets the core queue the next word
// while the current one drains; an optional inter-byte gap paces slow sinks.
//
// Parameters:
//   MSB_FIRST  - 0: bytes [7:0],[15:8],[23:16],[31:24]; 1: reverse order
//   GAP_CYCLES - idle cycles after each transferred byte (0..255)
// Ports:
//   Clk   - system clock, rising edge
//   ARstn - asynchronous active-low reset
//   bus   - byte_egress_if.slave (word handshake, byte handshake, Busy)
// -----------------------------------------------------------------------------
module byte_egress #(
   parameter bit MSB_FIRST  = 1'b0,
   parameter int GAP_CYCLES = 0
) (
   input logic          Clk,
   input logic          ARstn,
   byte_egress_if.slave bus
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SEND,
      ST_GAP
   } state_t;

   localparam bit         USE_GAP  = (GAP_CYCLES > 0);
   // Value of the gap counter on the final idle cycle of a gap.
   localparam logic [7:0] GAP_LAST = USE_GAP ? 8'(GAP_CYCLES - 1) : 8'd0;

   state_t      state;
   logic [31:0] shift_reg;     // remaining bytes of the current word, head first
   logic [31:0] pend_reg;
   logic        pend_valid;
   logic [1:0]  byte_idx;
   logic [7:0]  gap_cnt;
   logic [7:0]  data_q;
   logic        data_valid_q;
   logic        rdy_q;
   logic        busy_q;

   // Byte currently at the head of a word, in link order.
   function automatic logic [7:0] head(input logic [31:0] w);
      return MSB_FIRST ? w[31:24] : w[7:0];
   endfunction

   // Drop the head byte so the next one moves into the head position.
   function automatic logic [31:0] advance(input logic [31:0] w);
      return MSB_FIRST ? {w[23:0], 8'h00} : {8'h00, w[31:8]};
   endfunction

   logic        accept;
   logic        xfer;
   logic        last_xfer;
   logic [31:0] next_shift;
   logic [31:0] refill_word;

   assign accept      = bus.TxWordValid & rdy_q;
   // data_valid_q is only ever set in SEND, so this is a byte transfer.
   assign xfer        = data_valid_q & ~bus.Rdyn;
   assign last_xfer   = xfer & (byte_idx == 2'd3);
   assign next_shift  = advance(shift_reg);
   // Word that follows the last byte: the queued one, or a word arriving on
   // that very edge when nothing was queued.
   assign refill_word = pend_valid ? pend_reg : bus.TxWord;

   // NOTE: every state register uses non-blocking assignment so all of them
   // update together from values sampled before the edge; later assignments
   // in the same pass simply override earlier ones.
   always_ff @(posedge Clk or negedge ARstn) begin
      // NOTE: the pending buffer and shift register are reset along with the
      // control state so a reset mid-word leaves nothing that could leak out.
      if (!ARstn) begin
         state        <= ST_IDLE;
         shift_reg    <= '0;
         pend_reg     <= '0;
         pend_valid   <= 1'b0;
         byte_idx     <= '0;
         gap_cnt      <= '0;
         data_q       <= '0;
         data_valid_q <= 1'b0;
         rdy_q        <= 1'b1;
         busy_q       <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  shift_reg    <= bus.TxWord;
                  data_q       <= head(bus.TxWord);
                  byte_idx     <= '0;
                  data_valid_q <= 1'b1;
                  busy_q       <= 1'b1;
                  state        <= ST_SEND;
               end
            end

            ST_SEND: begin
               // A word arriving on the last-byte edge goes straight to shift.
               if (accept && !last_xfer) begin
                  pend_reg   <= bus.TxWord;
                  pend_valid <= 1'b1;
                  rdy_q      <= 1'b0;
               end
               if (xfer) begin
                  if (byte_idx != 2'd3) begin
                     byte_idx  <= byte_idx + 2'd1;
                     shift_reg <= next_shift;
                     if (USE_GAP) begin
                        state        <= ST_GAP;
                        gap_cnt      <= '0;
                        data_valid_q <= 1'b0;
                     end else begin
                        data_q <= head(next_shift);
                     end
                  end else if (pend_valid || accept) begin
                     shift_reg  <= refill_word;
                     byte_idx   <= '0;
                     pend_valid <= 1'b0;
                     rdy_q      <= 1'b1;
                     if (USE_GAP) begin
                        state        <= ST_GAP;
                        gap_cnt      <= '0;
                        data_valid_q <= 1'b0;
                     end else begin
                        data_q <= head(refill_word);
                     end
                  end else begin
                     state        <= ST_IDLE;
                     data_valid_q <= 1'b0;
                     busy_q       <= 1'b0;
                  end
               end
            end

            ST_GAP: begin
               if (accept) begin
                  pend_reg   <= bus.TxWord;
                  pend_valid <= 1'b1;
                  rdy_q      <= 1'b0;
               end
               if (gap_cnt == GAP_LAST) begin
                  state        <= ST_SEND;
                  data_valid_q <= 1'b1;
                  data_q       <= head(shift_reg);
               end else begin
                  gap_cnt <= gap_cnt + 8'd1;
               end
            end

            default: begin
               state        <= ST_IDLE;
               data_valid_q <= 1'b0;
               busy_q       <= pend_valid;
            end
         endcase
      end
   end

   assign bus.TxWordRdy = rdy_q;
   assign bus.Data      = data_q;
   assign bus.DataValid = data_valid_q;
   assign bus.Busy      = busy_q;

endmodule

// File: tb/tb_byte_egress.sv
// -----------------------------------------------------------------------------
// tb_byte_egress
// Directed bench for byte_egress. Two instances share clock and reset:
//   u_lsb : MSB_FIRST=0, GAP_CYCLES=0
//   u_msb : MSB_FIRST=1, GAP_CYCLES=2
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_byte_egress;

   logic Clk = 1'b0;
   logic ARstn;

   always #5 Clk = ~Clk;

   byte_egress_if if0 ();
   byte_egress_if if1 ();

   byte_egress #(.MSB_FIRST(1'b0), .GAP_CYCLES(0)) u_lsb (
      .Clk   (Clk),
      .ARstn (ARstn),
      .bus   (if0)
   );

   byte_egress #(.MSB_FIRST(1'b1), .GAP_CYCLES(2)) u_msb (
      .Clk   (Clk),
      .ARstn (ARstn),
      .bus   (if1)
   );

   int checks = 0;
   int errors = 0;

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic test_reset();
      ARstn           = 1'b0;
      if0.TxWord      = '0;
      if0.TxWordValid = 1'b0;
      if0.Rdyn        = 1'b1;
      if1.TxWord      = '0;
      if1.TxWordValid = 1'b0;
      if1.Rdyn        = 1'b1;
      repeat (3) tick();
      checks++; if (if0.TxWordRdy !== 1'b1) begin errors++; $display("FAIL reset_rdy: got %b expected 1", if0.TxWordRdy); end
      checks++; if (if0.DataValid !== 1'b0) begin errors++; $display("FAIL reset_dv: got %b expected 0", if0.DataValid); end
      checks++; if (if0.Data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", if0.Data); end
      checks++; if (if0.Busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", if0.Busy); end
      checks++; if (if1.TxWordRdy !== 1'b1 || if1.DataValid !== 1'b0) begin
         errors++; $display("FAIL reset_msb: got rdy=%b dv=%b expected rdy=1 dv=0", if1.TxWordRdy, if1.DataValid);
      end
      ARstn = 1'b1;
      tick();
   endtask

   task automatic test_single();
      logic [7:0] exp_b[4] = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
      if0.Rdyn        = 1'b0;
      if0.TxWord      = 32'hA1B2C3D4;
      if0.TxWordValid = 1'b1;
      checks++; if (if0.TxWordRdy !== 1'b1) begin errors++; $display("FAIL single_rdy: got %b expected 1", if0.TxWordRdy); end
      tick();
      if0.TxWordValid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         checks++; if (if0.DataValid !== 1'b1 || if0.Data !== exp_b[i]) begin
            errors++; $display("FAIL single_byte%0d: got dv=%b data=%h expected dv=1 data=%h", i, if0.DataValid, if0.Data, exp_b[i]);
         end
         checks++; if (if0.Busy !== 1'b1) begin errors++; $display("FAIL single_busy%0d: got %b expected 1", i, if0.Busy); end
         tick();
      end
      checks++; if (if0.DataValid !== 1'b0) begin errors++; $display("FAIL single_end_dv: got %b expected 0", if0.DataValid); end
      checks++; if (if0.Busy !== 1'b0) begin errors++; $display("FAIL single_end_busy: got %b expected 0", if0.Busy); end
      checks++; if (if0.Data !== 8'hA1) begin errors++; $display("FAIL single_hold: got %h expected a1", if0.Data); end
   endtask

   task automatic test_back_to_back();
      logic exp_rdy[8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      if0.Rdyn        = 1'b0;
      if0.TxWord      = 32'h03020100;
      if0.TxWordValid = 1'b1;
      tick();
      if0.TxWord = 32'h07060504;
      for (int k = 0; k < 8; k++) begin
         checks++; if (if0.DataValid !== 1'b1 || if0.Data !== 8'(k)) begin
            errors++; $display("FAIL b2b_byte%0d: got dv=%b data=%h expected dv=1 data=%h", k, if0.DataValid, if0.Data, 8'(k));
         end
         checks++; if (if0.TxWordRdy !== exp_rdy[k]) begin
            errors++; $display("FAIL b2b_rdy%0d: got %b expected %b", k, if0.TxWordRdy, exp_rdy[k]);
         end
         tick();
         if (k == 0) if0.TxWordValid = 1'b0;
      end
      checks++; if (if0.DataValid !== 1'b0 || if0.Busy !== 1'b0) begin
         errors++; $display("FAIL b2b_end: got dv=%b busy=%b expected dv=0 busy=0", if0.DataValid, if0.Busy);
      end
   endtask

   task automatic test_backpressure();
      logic [7:0] exp_b[4] = '{8'h44, 8'h33, 8'h22, 8'h11};
      logic [7:0] got[8];
      int nx = 0;
      if0.Rdyn        = 1'b0;
      if0.TxWord      = 32'h11223344;
      if0.TxWordValid = 1'b1;
      tick();
      if0.TxWordValid = 1'b0;
      for (int c = 0; c < 12; c++) begin
         if0.Rdyn = (c >= 1 && c <= 5);
         if (c >= 1 && c <= 5) begin
            checks++; if (if0.DataValid !== 1'b1 || if0.Data !== 8'h33) begin
               errors++; $display("FAIL bp_stall%0d: got dv=%b data=%h expected dv=1 data=33", c, if0.DataValid, if0.Data);
            end
         end
         if (if0.DataValid === 1'b1 && if0.Rdyn === 1'b0) begin
            if (nx < 8) got[nx] = if0.Data;
            nx++;
         end
         tick();
      end
      if0.Rdyn = 1'b0;
      checks++; if (nx != 4) begin errors++; $display("FAIL bp_count: got %0d expected 4", nx); end
      for (int i = 0; i < 4; i++) begin
         checks++; if (i >= nx || got[i] !== exp_b[i]) begin
            errors++; $display("FAIL bp_byte%0d: got %h expected %h", i, (i < nx) ? got[i] : 8'hxx, exp_b[i]);
         end
      end
   endtask

   task automatic test_msb_gap();
      logic [7:0] exp_b[4] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
      logic [7:0] got[8];
      int gaps[8];
      int nx  = 0;
      int low = 0;
      if1.Rdyn        = 1'b0;
      if1.TxWord      = 32'hDEADBEEF;
      if1.TxWordValid = 1'b1;
      tick();
      if1.TxWordValid = 1'b0;
      for (int c = 0; c < 24; c++) begin
         if (if1.DataValid === 1'b1) begin
            if (nx > 0 && nx < 8) gaps[nx-1] = low;
            if (nx < 8) got[nx] = if1.Data;
            low = 0;
            nx++;
         end else if (nx > 0 && nx < 4) begin
            low++;
         end
         tick();
      end
      checks++; if (nx != 4) begin errors++; $display("FAIL gap_count: got %0d expected 4", nx); end
      for (int i = 0; i < 4; i++) begin
         checks++; if (i >= nx || got[i] !== exp_b[i]) begin
            errors++; $display("FAIL gap_byte%0d: got %h expected %h", i, (i < nx) ? got[i] : 8'hxx, exp_b[i]);
         end
      end
      for (int i = 0; i < 3; i++) begin
         checks++; if (i + 1 >= nx || gaps[i] != 2) begin
            errors++; $display("FAIL gap_len%0d: got %0d expected 2", i, (i + 1 < nx) ? gaps[i] : -1);
         end
      end
      checks++; if (if1.Busy !== 1'b0) begin errors++; $display("FAIL gap_end_busy: got %b expected 0", if1.Busy); end
   endtask

   task automatic test_reset_mid();
      if0.Rdyn        = 1'b0;
      if0.TxWord      = 32'hCAFEF00D;
      if0.TxWordValid = 1'b1;
      tick();
      if0.TxWord = 32'h12345678;
      checks++; if (if0.Data !== 8'h0D) begin errors++; $display("FAIL rst_b0: got %h expected 0d", if0.Data); end
      tick();
      if0.TxWordValid = 1'b0;
      checks++; if (if0.Data !== 8'hF0 || if0.TxWordRdy !== 1'b0) begin
         errors++; $display("FAIL rst_b1: got data=%h rdy=%b expected data=f0 rdy=0", if0.Data, if0.TxWordRdy);
      end
      tick();
      ARstn = 1'b0;
      #1;
      checks++; if (if0.DataValid !== 1'b0) begin errors++; $display("FAIL rst_async_dv: got %b expected 0", if0.DataValid); end
      checks++; if (if0.TxWordRdy !== 1'b1) begin errors++; $display("FAIL rst_async_rdy: got %b expected 1", if0.TxWordRdy); end
      checks++; if (if0.Busy !== 1'b0 || if0.Data !== 8'h00) begin
         errors++; $display("FAIL rst_async_out: got busy=%b data=%h expected busy=0 data=00", if0.Busy, if0.Data);
      end
      tick();
      ARstn = 1'b1;
      for (int c = 0; c < 6; c++) begin
         checks++; if (if0.DataValid !== 1'b0 || if0.Busy !== 1'b0) begin
            errors++; $display("FAIL rst_quiet%0d: got dv=%b busy=%b expected dv=0 busy=0", c, if0.DataValid, if0.Busy);
         end
         tick();
      end
      if0.TxWord      = 32'h00000055;
      if0.TxWordValid = 1'b1;
      tick();
      if0.TxWordValid = 1'b0;
      checks++; if (if0.DataValid !== 1'b1 || if0.Data !== 8'h55) begin
         errors++; $display("FAIL rst_next: got dv=%b data=%h expected dv=1 data=55", if0.DataValid, if0.Data);
      end
      repeat (4) tick();
      checks++; if (if0.DataValid !== 1'b0 || if0.Busy !== 1'b0) begin
         errors++; $display("FAIL rst_next_end: got dv=%b busy=%b expected dv=0 busy=0", if0.DataValid, if0.Busy);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_backpressure();
      test_msb_gap();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: run did not complete, got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
